// File: rtl/regfile_ctrl.sv
// regfile_ctrl: multi-cycle control FSM sequencing register-file reads, ALU work and writeback.
// Optional feature: define RC_ILLEGAL_TRAP_EN to trap illegal encodings in a HALT state.
module regfile_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic [1:0]  shift,
    output logic [1:0]  aluop,
    output logic [15:0] sximm8,
    output logic        err
);
    typedef enum logic [2:0] {WAIT, DECODE, GET_A, GET_B, ALU, WR_REG, WR_IMM, HALT} state_t;
    typedef enum logic [2:0] {K_MOV_IMM, K_MOV_REG, K_MVN, K_ARITH, K_CMP, K_ILLEGAL} kind_t;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       vsel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } ctrl_t;

    state_t      state, next_state;
    logic [15:0] ir, next_ir;
    ctrl_t       ctrl;

    function automatic kind_t classify(input logic [4:0] opc_op);
        case (opc_op)
            5'b110_10:            return K_MOV_IMM;
            5'b110_00:            return K_MOV_REG;
            5'b101_11:            return K_MVN;
            5'b101_01:            return K_CMP;
            5'b101_00, 5'b101_10: return K_ARITH;
            default:              return K_ILLEGAL;
        endcase
    endfunction

    // Moore control word for a state, given the instruction held in that state.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [15:0] iv);
        ctrl_t c;
        c = '0;
        case (st)
            WAIT:   c.w = 1'b1;
            GET_A:  begin c.readnum = iv[10:8]; c.loada = 1'b1; end
            GET_B:  begin c.readnum = iv[2:0];  c.loadb = 1'b1; end
            ALU: begin
                c.shift = iv[4:3];
                c.asel  = (iv[15:13] == 3'b110);
                c.aluop = c.asel ? 2'b00 : iv[12:11];
                if (classify(iv[15:11]) == K_CMP) c.loads = 1'b1;
                else                              c.loadc = 1'b1;
            end
            WR_REG: begin c.writenum = iv[7:5];  c.write = 1'b1; end
            WR_IMM: begin c.writenum = iv[10:8]; c.write = 1'b1; c.vsel = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        next_ir    = ir;
        case (state)
            WAIT: if (s) begin
                next_ir = in;
                // Register ops dispatch on the capture edge; that cycle stands in for DECODE.
                case (classify(in[15:11]))
                    K_MOV_REG, K_MVN: next_state = GET_B;
                    K_ARITH, K_CMP:   next_state = GET_A;
                    default:          next_state = DECODE;
                endcase
            end
            DECODE: begin
                if (classify(ir[15:11]) == K_MOV_IMM) next_state = WR_IMM;
                else begin
`ifdef RC_ILLEGAL_TRAP_EN
                    next_state = HALT;
`else
                    next_state = WAIT;
`endif
                end
            end
            GET_A:  next_state = GET_B;
            GET_B:  next_state = ALU;
            ALU:    next_state = (classify(ir[15:11]) == K_CMP) ? WAIT : WR_REG;
            WR_REG: next_state = WAIT;
            WR_IMM: next_state = WAIT;
`ifdef RC_ILLEGAL_TRAP_EN
            HALT:   next_state = HALT;
`else
            HALT:   next_state = WAIT;
`endif
            default: next_state = WAIT;
        endcase
    end

`ifdef RC_ILLEGAL_TRAP_EN
    logic halted;
    assign err = halted;
`else
    assign err = 1'b0;
`endif

    // NOTE: outputs are registered from the next state, so the async reset clears them immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= WAIT;
            ir     <= '0;
            ctrl   <= ctrl_for(WAIT, 16'h0000);
`ifdef RC_ILLEGAL_TRAP_EN
            halted <= 1'b0;
`endif
        end else begin
            state  <= next_state;
            ir     <= next_ir;
            ctrl   <= ctrl_for(next_state, next_ir);
`ifdef RC_ILLEGAL_TRAP_EN
            halted <= (next_state == HALT);
`endif
        end
    end

    assign {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, vsel, shift, aluop} = ctrl;
    assign bsel   = 1'b0;
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: directed and randomized checks of regfile_ctrl against a per-instruction cycle model.
// Honours RC_ILLEGAL_TRAP_EN the same way the design does.
module tb_regfile_ctrl;
    logic        clk = 1'b0;
    logic        reset, s;
    logic [15:0] in;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, vsel, err;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, aluop;
    logic [15:0] sximm8;

    regfile_ctrl dut (
        .clk(clk), .reset(reset), .s(s), .in(in), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .aluop(aluop),
        .sximm8(sximm8), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write, loada, loadb, loadc, loads, asel, bsel, vsel;
        logic [1:0]  shift, aluop;
        logic [15:0] sximm8;
        logic        err;
    } ctrl_t;

    int    checks = 0;
    int    errors = 0;
    ctrl_t exp_q[$];
    ctrl_t seen_q[$];
    bit    exp_halt;

    function automatic logic [15:0] sext8(input logic [7:0] b);
        int v;
        v = int'(b);
        if (v > 127) v = v - 256;
        return 16'(v);
    endfunction

    function automatic ctrl_t idle_vec(input logic [15:0] sx, input bit ready);
        ctrl_t c;
        c = '0;
        c.w = ready;
        c.sximm8 = sx;
        return c;
    endfunction

    function automatic ctrl_t observe();
        ctrl_t c;
        c.w = w; c.readnum = readnum; c.writenum = writenum; c.write = write;
        c.loada = loada; c.loadb = loadb; c.loadc = loadc; c.loads = loads;
        c.asel = asel; c.bsel = bsel; c.vsel = vsel; c.shift = shift; c.aluop = aluop;
        c.sximm8 = sximm8; c.err = err;
        return c;
    endfunction

    // Expected control vector for each busy cycle after the capture edge, per instruction class.
    function automatic void build_expect(input logic [15:0] instr);
        logic [2:0] opc;
        logic [1:0] op;
        ctrl_t base, ga, gb, al, wr;
        opc = instr[15:13];
        op  = instr[12:11];
        base = idle_vec(sext8(instr[7:0]), 1'b0);
        ga = base; ga.readnum = instr[10:8]; ga.loada = 1'b1;
        gb = base; gb.readnum = instr[2:0];  gb.loadb = 1'b1;
        al = base; al.shift = instr[4:3];
        wr = base; wr.writenum = instr[7:5]; wr.write = 1'b1;
        exp_q.delete();
        exp_halt = 1'b0;
        if (opc == 3'b110 && op == 2'b10) begin
            wr.writenum = instr[10:8]; wr.vsel = 1'b1;
            exp_q.push_back(base); exp_q.push_back(wr);
        end else if (opc == 3'b110 && op == 2'b00) begin
            al.asel = 1'b1; al.aluop = 2'b00; al.loadc = 1'b1;
            exp_q.push_back(gb); exp_q.push_back(al); exp_q.push_back(wr);
        end else if (opc == 3'b101 && op == 2'b11) begin
            al.aluop = op; al.loadc = 1'b1;
            exp_q.push_back(gb); exp_q.push_back(al); exp_q.push_back(wr);
        end else if (opc == 3'b101 && op == 2'b01) begin
            al.aluop = op; al.loads = 1'b1;
            exp_q.push_back(ga); exp_q.push_back(gb); exp_q.push_back(al);
        end else if (opc == 3'b101) begin
            al.aluop = op; al.loadc = 1'b1;
            exp_q.push_back(ga); exp_q.push_back(gb); exp_q.push_back(al); exp_q.push_back(wr);
        end else begin
            exp_q.push_back(base);
`ifdef RC_ILLEGAL_TRAP_EN
            exp_halt = 1'b1;
`endif
        end
    endfunction

    // Starts at a negedge in WAIT; returns at the negedge of the next WAIT cycle (or after HALT cycles).
    task automatic run_instr(input logic [15:0] instr, input bit hold_s, input bit scramble,
                             input string name, output int lat);
        ctrl_t obs, want;
        s = 1'b1;
        in = instr;
        build_expect(instr);
        seen_q.delete();
        lat = 0;
        foreach (exp_q[i]) begin
            @(negedge clk);
            obs = observe();
            seen_q.push_back(obs);
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %h, expected %h", name, i, obs, exp_q[i]);
            end
            if (scramble) begin
                in = 16'($urandom);
                if (!hold_s) s = 1'($urandom);
            end else if (!hold_s) s = 1'b0;
        end
        want = idle_vec(sext8(instr[7:0]), !exp_halt);
        want.err = exp_halt;
        for (int n = 0; n < (exp_halt ? 3 : 1); n++) begin
            @(negedge clk);
            obs = observe();
            seen_q.push_back(obs);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL %s settle cycle %0d: got %h, expected %h", name, n, obs, want);
            end
            if (exp_halt) begin s = 1'b1; in = 16'($urandom); end
        end
        foreach (seen_q[i]) if (lat == 0 && seen_q[i].w) lat = i + 1;
        s = hold_s;
    endtask

    task automatic test_reset();
        ctrl_t obs;
        s = 1'b0; in = 16'h0000; reset = 1'b0;
        #1 reset = 1'b1;
        #2 obs = observe();
        checks++;
        if (obs !== idle_vec(16'h0000, 1'b1)) begin
            errors++; $display("FAIL reset_async: got %h, expected %h", obs, idle_vec(16'h0000, 1'b1));
        end
        @(negedge clk);
        obs = observe();
        checks++;
        if (obs !== idle_vec(16'h0000, 1'b1)) begin
            errors++; $display("FAIL reset_held: got %h, expected %h", obs, idle_vec(16'h0000, 1'b1));
        end
        reset = 1'b0;
        @(negedge clk);
        obs = observe();
        checks++;
        if (obs !== idle_vec(16'h0000, 1'b1)) begin
            errors++; $display("FAIL wait_idle: got %h, expected %h", obs, idle_vec(16'h0000, 1'b1));
        end
    endtask

    task automatic test_mov_imm();
        int lat;
        run_instr(16'hD0FB, 1'b0, 1'b0, "mov_imm", lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL mov_imm_latency: got %0d, expected 3", lat); end
        checks++;
        if ({seen_q[1].writenum, seen_q[1].write, seen_q[1].vsel, seen_q[1].sximm8} !== {3'd0, 1'b1, 1'b1, 16'hFFFB}) begin
            errors++;
            $display("FAIL mov_imm_wr: got wn=%0d wr=%b vsel=%b sx=%h, expected wn=0 wr=1 vsel=1 sx=fffb",
                     seen_q[1].writenum, seen_q[1].write, seen_q[1].vsel, seen_q[1].sximm8);
        end
    endtask

    task automatic test_add();
        int lat;
        run_instr(16'hA148, 1'b0, 1'b1, "add", lat);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL add_latency: got %0d, expected 5", lat); end
        checks++;
        if ({seen_q[0].readnum, seen_q[0].loada, seen_q[1].readnum, seen_q[1].loadb} !== {3'd1, 1'b1, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL add_operands: got rn=%0d la=%b rm=%0d lb=%b, expected 1 1 0 1",
                     seen_q[0].readnum, seen_q[0].loada, seen_q[1].readnum, seen_q[1].loadb);
        end
        checks++;
        if ({seen_q[2].shift, seen_q[2].aluop, seen_q[2].loadc, seen_q[3].writenum, seen_q[3].write}
            !== {2'b01, 2'b00, 1'b1, 3'd2, 1'b1}) begin
            errors++;
            $display("FAIL add_alu_wb: got sh=%b op=%b lc=%b wn=%0d wr=%b, expected 01 00 1 2 1",
                     seen_q[2].shift, seen_q[2].aluop, seen_q[2].loadc, seen_q[3].writenum, seen_q[3].write);
        end
    endtask

    task automatic test_cmp();
        int lat;
        bit any_write;
        run_instr(16'hAB04, 1'b0, 1'b1, "cmp", lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL cmp_latency: got %0d, expected 4", lat); end
        checks++;
        if ({seen_q[2].loads, seen_q[2].loadc} !== 2'b10) begin
            errors++; $display("FAIL cmp_status: got loads=%b loadc=%b, expected 1 0", seen_q[2].loads, seen_q[2].loadc);
        end
        any_write = 1'b0;
        foreach (seen_q[i]) any_write |= seen_q[i].write;
        checks++;
        if (any_write !== 1'b0) begin errors++; $display("FAIL cmp_no_write: got write=1, expected 0"); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_instr(16'hD0FB, 1'b1, 1'b1, "b2b_mov_imm", lat);
        run_instr(16'hA148, 1'b1, 1'b1, "b2b_add", lat);
        s = 1'b0;
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL b2b_latency: got %0d, expected 5", lat); end
        checks++;
        if ({seen_q[3].writenum, seen_q[3].write, seen_q[3].sximm8} !== {3'd2, 1'b1, 16'h0048}) begin
            errors++;
            $display("FAIL b2b_second_capture: got wn=%0d wr=%b sx=%h, expected 2 1 0048",
                     seen_q[3].writenum, seen_q[3].write, seen_q[3].sximm8);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] r;
        logic [15:0] instr;
        for (int it = 0; it < 40; it++) begin
            r = $urandom;
            case ($urandom_range(0, 5))
                0: instr = {5'b110_10, r[10:0]};
                1: instr = {5'b110_00, r[10:0]};
                2: instr = {5'b101_11, r[10:0]};
                3: instr = {5'b101_01, r[10:0]};
                4: instr = {3'b101, r[11] ? 2'b10 : 2'b00, r[10:0]};
`ifdef RC_ILLEGAL_TRAP_EN
                default: instr = {5'b101_00, r[10:0]};
`else
                default: instr = r[31:16];
`endif
            endcase
            run_instr(instr, 1'($urandom), 1'b1, "random", lat);
        end
        s = 1'b0;
    endtask

    task automatic test_reset_mid();
        ctrl_t obs;
        s = 1'b1; in = 16'hA148;
        @(negedge clk);
        s = 1'b0;
        @(negedge clk);
        obs = observe();
        checks++;
        if ({obs.readnum, obs.loadb} !== {3'd0, 1'b1}) begin
            errors++; $display("FAIL mid_get_b: got rn=%0d lb=%b, expected 0 1", obs.readnum, obs.loadb);
        end
        #2 reset = 1'b1;
        #1 obs = observe();
        checks++;
        if (obs !== idle_vec(16'h0000, 1'b1)) begin
            errors++; $display("FAIL mid_reset_async: got %h, expected %h", obs, idle_vec(16'h0000, 1'b1));
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            obs = observe();
            checks++;
            if ({obs.write, obs.w} !== 2'b01) begin
                errors++; $display("FAIL mid_reset_after %0d: got write=%b w=%b, expected 0 1", n, obs.write, obs.w);
            end
        end
    endtask

    task automatic test_illegal();
        int lat;
        bit any_write;
        ctrl_t obs;
        run_instr(16'h0000, 1'b0, 1'b0, "illegal", lat);
        any_write = 1'b0;
        foreach (seen_q[i]) any_write |= seen_q[i].write;
        checks++;
        if (any_write !== 1'b0) begin errors++; $display("FAIL illegal_no_write: got write=1, expected 0"); end
`ifdef RC_ILLEGAL_TRAP_EN
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL illegal_halt: w returned after %0d edges, expected never", lat); end
        s = 1'b0;
        reset = 1'b1;
        #1 obs = observe();
        checks++;
        if (obs !== idle_vec(16'h0000, 1'b1)) begin
            errors++; $display("FAIL halt_reset: got %h, expected %h", obs, idle_vec(16'h0000, 1'b1));
        end
        @(negedge clk);
        reset = 1'b0;
`else
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL illegal_latency: got %0d, expected 2", lat); end
`endif
        @(negedge clk);
        obs = observe();
        checks++;
        if ({obs.w, obs.err} !== 2'b10) begin
            errors++; $display("FAIL illegal_recovered: got w=%b err=%b, expected 1 0", obs.w, obs.err);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mov_imm();
        test_add();
        test_cmp();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
